// File: rtl/sad_scan_ctrl_pkg.sv
// Shared types and width helpers for the SAD raster-scan sequencer.
// Optional build macro: SAD_THRESH_EN (threshold early-exit).
package sad_scan_ctrl_pkg;

    localparam int IMG_W_DEF = 320;
    localparam int IMG_H_DEF = 240;
    localparam int TPL_W_DEF = 50;
    localparam int TPL_H_DEF = 80;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_EVAL  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_STEP  = 3'd4,
        ST_DONE  = 3'd5
    } scan_state_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Score width able to hold a popcount of 'bits' ones.
    function automatic int score_w(input int bits);
        return $clog2(bits + 1);
    endfunction

    localparam int SCORE_W_DEF = score_w(TPL_W_DEF * TPL_H_DEF);
    localparam int X_W_DEF     = cnt_w(IMG_W_DEF);
    localparam int Y_W_DEF     = cnt_w(IMG_H_DEF);

endpackage

// File: rtl/sad_scan_ctrl_if.sv
// Host / linebuffer / popcount handshake bundle of the scan sequencer.
// Optional build macro: SAD_THRESH_EN adds thresh and hit.
interface sad_scan_ctrl_if #(
    parameter int SCORE_W = 12,
    parameter int X_W     = 9,
    parameter int Y_W     = 8
);
    logic               start;
    logic               abort;
    logic               busy;
    logic               done;
    logic               lb_req;
    logic               lb_ack;
    logic               lb_row;
    logic               pc_start;
    logic               pc_valid;
    logic [SCORE_W-1:0] pc_score;
    logic [X_W-1:0]     best_x;
    logic [Y_W-1:0]     best_y;
    logic [SCORE_W-1:0] best_score;
`ifdef SAD_THRESH_EN
    logic [SCORE_W-1:0] thresh;
    logic               hit;

    modport master (
        input  start, abort, lb_ack, pc_valid, pc_score, thresh,
        output busy, done, lb_req, lb_row, pc_start, best_x, best_y, best_score, hit
    );
    modport slave (
        output start, abort, lb_ack, pc_valid, pc_score, thresh,
        input  busy, done, lb_req, lb_row, pc_start, best_x, best_y, best_score, hit
    );
`else
    modport master (
        input  start, abort, lb_ack, pc_valid, pc_score,
        output busy, done, lb_req, lb_row, pc_start, best_x, best_y, best_score
    );
    modport slave (
        output start, abort, lb_ack, pc_valid, pc_score,
        input  busy, done, lb_req, lb_row, pc_start, best_x, best_y, best_score
    );
`endif
endinterface

// File: rtl/sad_scan_ctrl_best_tracker.sv
// Keeps the lowest popcount score and its window position (earliest wins ties).
// Optional build macro: SAD_THRESH_EN adds threshold hit / early-exit request.
module sad_scan_ctrl_best_tracker #(
    parameter int SCORE_W = 12,
    parameter int X_W     = 9,
    parameter int Y_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               valid,
    input  logic [SCORE_W-1:0] score,
    input  logic [X_W-1:0]     x,
    input  logic [Y_W-1:0]     y,
`ifdef SAD_THRESH_EN
    input  logic [SCORE_W-1:0] thresh,
    output logic               hit,
    output logic               early,
`endif
    output logic [X_W-1:0]     best_x,
    output logic [Y_W-1:0]     best_y,
    output logic [SCORE_W-1:0] best_score
);

    logic [X_W-1:0]     best_x_r;
    logic [Y_W-1:0]     best_y_r;
    logic [SCORE_W-1:0] best_score_r;
    logic               better_s;
    logic               take_s;
`ifdef SAD_THRESH_EN
    logic               thr_s;
    logic               hit_r;
`endif

    // Decide whether the incoming result replaces the stored best.
    always_comb begin
        better_s = (score < best_score_r);
`ifdef SAD_THRESH_EN
        thr_s    = (score <= thresh);
        take_s   = valid && (better_s || thr_s);
`else
        take_s   = valid && better_s;
`endif
    end

    // Best-match storage, re-armed to all-ones score at each scan start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_x_r     <= {X_W{1'b0}};
            best_y_r     <= {Y_W{1'b0}};
            best_score_r <= {SCORE_W{1'b1}};
        end else if (clear) begin
            best_x_r     <= {X_W{1'b0}};
            best_y_r     <= {Y_W{1'b0}};
            best_score_r <= {SCORE_W{1'b1}};
        end else if (take_s) begin
            best_x_r     <= x;
            best_y_r     <= y;
            best_score_r <= score;
        end else begin
            best_x_r     <= best_x_r;
            best_y_r     <= best_y_r;
            best_score_r <= best_score_r;
        end
    end

`ifdef SAD_THRESH_EN
    // Sticky threshold-hit flag for the current scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_r <= 1'b0;
        end else if (clear) begin
            hit_r <= 1'b0;
        end else if (valid && thr_s) begin
            hit_r <= 1'b1;
        end else begin
            hit_r <= hit_r;
        end
    end

    assign hit   = hit_r;
    assign early = valid && thr_s;
`endif

    assign best_x     = best_x_r;
    assign best_y     = best_y_r;
    assign best_score = best_score_r;

endmodule

// File: rtl/sad_scan_ctrl.sv
// Raster-scan sequencer: primes/steps the linebuffer, launches popcounts, tracks best match.
// Optional build macro: SAD_THRESH_EN (stop at the first score <= thresh).
module sad_scan_ctrl
    import sad_scan_ctrl_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int TPL_W   = TPL_W_DEF,
    parameter int TPL_H   = TPL_H_DEF,
    parameter int SCORE_W = score_w(TPL_W * TPL_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    sad_scan_ctrl_if.master bus
);

    localparam int X_W = cnt_w(IMG_W);
    localparam int Y_W = cnt_w(IMG_H);
    localparam int P_W = cnt_w(TPL_W);

    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - TPL_W);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - TPL_H);
    localparam logic [P_W-1:0] P_LAST = P_W'(TPL_W - 1);

    scan_state_t        state_r;
    logic [X_W-1:0]     x_r;
    logic [Y_W-1:0]     y_r;
    logic [P_W-1:0]     prime_r;
    logic               busy_r;
    logic               done_r;
    logic               lb_req_r;
    logic               lb_row_r;
    logic               pc_start_r;

    logic               start_acc_s;
    logic               eval_s;
    logic               early_s;
    logic [X_W-1:0]     best_x_s;
    logic [Y_W-1:0]     best_y_s;
    logic [SCORE_W-1:0] best_score_s;

    // Accepted start and accepted popcount result; abort masks both.
    always_comb begin
        start_acc_s = (state_r == ST_IDLE) && bus.start && !bus.abort;
        eval_s      = (state_r == ST_WAIT) && bus.pc_valid && !bus.abort;
    end

    sad_scan_ctrl_best_tracker #(
        .SCORE_W (SCORE_W),
        .X_W     (X_W),
        .Y_W     (Y_W)
    ) u_best (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_acc_s),
        .valid      (eval_s),
        .score      (bus.pc_score),
        .x          (x_r),
        .y          (y_r),
`ifdef SAD_THRESH_EN
        .thresh     (bus.thresh),
        .hit        (bus.hit),
        .early      (early_s),
`endif
        .best_x     (best_x_s),
        .best_y     (best_y_s),
        .best_score (best_score_s)
    );

`ifndef SAD_THRESH_EN
    assign early_s = 1'b0;
`endif

    // Scan sequencer: state, position counters and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            x_r        <= {X_W{1'b0}};
            y_r        <= {Y_W{1'b0}};
            prime_r    <= {P_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            lb_req_r   <= 1'b0;
            lb_row_r   <= 1'b0;
            pc_start_r <= 1'b0;
        end else if (bus.abort && (state_r != ST_IDLE)) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            lb_req_r   <= 1'b0;
            lb_row_r   <= 1'b0;
            pc_start_r <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            pc_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_acc_s) begin
                        state_r  <= ST_SHIFT;
                        busy_r   <= 1'b1;
                        lb_req_r <= 1'b1;
                        lb_row_r <= 1'b1;
                        x_r      <= {X_W{1'b0}};
                        y_r      <= {Y_W{1'b0}};
                        prime_r  <= {P_W{1'b0}};
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    // After a row prime, prime_r stays at P_LAST so single steps go straight to EVAL.
                    if (lb_req_r && bus.lb_ack) begin
                        lb_row_r <= 1'b0;
                        if (prime_r < P_LAST) begin
                            prime_r <= prime_r + P_W'(1);
                        end else begin
                            lb_req_r   <= 1'b0;
                            pc_start_r <= 1'b1;
                            state_r    <= ST_EVAL;
                        end
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_EVAL: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eval_s && early_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else if (eval_s) begin
                        state_r <= ST_STEP;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_STEP: begin
                    if (x_r < X_LAST) begin
                        x_r      <= x_r + X_W'(1);
                        lb_req_r <= 1'b1;
                        state_r  <= ST_SHIFT;
                    end else if (y_r < Y_LAST) begin
                        x_r      <= {X_W{1'b0}};
                        y_r      <= y_r + Y_W'(1);
                        prime_r  <= {P_W{1'b0}};
                        lb_req_r <= 1'b1;
                        lb_row_r <= 1'b1;
                        state_r  <= ST_SHIFT;
                    end else begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                    lb_req_r <= 1'b0;
                    lb_row_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.lb_req     = lb_req_r;
    assign bus.lb_row     = lb_row_r;
    assign bus.pc_start   = pc_start_r;
    assign bus.best_x     = best_x_s;
    assign bus.best_y     = best_y_s;
    assign bus.best_score = best_score_s;

endmodule

// File: tb/tb_sad_scan_ctrl.sv
// Directed bench for sad_scan_ctrl on an 8x4 image with a 2x2 template (7x3 = 21 positions).
// Build with SAD_THRESH_EN defined to also exercise the threshold early exit.
module tb_sad_scan_ctrl;

    localparam int IMG_W   = 8;
    localparam int IMG_H   = 4;
    localparam int TPL_W   = 2;
    localparam int TPL_H   = 2;
    localparam int SCORE_W = 12;
    localparam int X_W     = 3;
    localparam int Y_W     = 2;
    localparam int NX      = IMG_W - TPL_W + 1;
    localparam int NPOS    = NX * (IMG_H - TPL_H + 1);
    localparam int ONES    = 4095;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sad_scan_ctrl_if #(.SCORE_W(SCORE_W), .X_W(X_W), .Y_W(Y_W)) bus ();

    sad_scan_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .TPL_W(TPL_W), .TPL_H(TPL_H), .SCORE_W(SCORE_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [SCORE_W-1:0] score_tab [NPOS];
    int lb_min = 0, lb_max = 0, pc_lat_min = 3, pc_lat_max = 3;
    int pos = 0, pcs_cnt = 0, row_cnt = 0, shift_cnt = 0, done_cnt = 0;
    int req_drop = 0, pc_dup = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill_tab(input int base);
        for (int i = 0; i < NPOS; i++) score_tab[i] = SCORE_W'(base);
    endtask

    // Linebuffer model: acks a pending request after a 0..lb_max cycle delay.
    initial begin
        int  lb_cnt  = 0;
        int  lb_tgt  = 0;
        bit  req_wait = 1'b0;
        bus.lb_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (req_wait && !bus.lb_req) req_drop++;
            bus.lb_ack = 1'b0;
            if (bus.lb_req && rst_n) begin
                if (lb_cnt >= lb_tgt) begin
                    bus.lb_ack = 1'b1;
                    shift_cnt++;
                    if (bus.lb_row) row_cnt++;
                    lb_cnt = 0;
                    lb_tgt = int'($urandom_range(lb_max, lb_min));
                end else begin
                    lb_cnt++;
                end
            end
            req_wait = bus.lb_req && !bus.lb_ack;
        end
    end

    // Popcount model: returns the table score for the raster position it counts itself.
    initial begin
        bit pc_pend  = 1'b0;
        bit prev_pcs = 1'b0;
        int pc_cd    = 0;
        logic [SCORE_W-1:0] pc_q = '0;
        bus.pc_valid = 1'b0;
        bus.pc_score = '0;
        forever begin
            @(negedge clk);
            bus.pc_valid = 1'b0;
            if (!rst_n) pc_pend = 1'b0;
            if (!bus.busy) pos = 0;
            if (pc_pend) begin
                pc_cd--;
                if (pc_cd <= 0) begin
                    bus.pc_valid = 1'b1;
                    bus.pc_score = pc_q;
                    pc_pend = 1'b0;
                end
            end
            if (bus.pc_start) begin
                if (prev_pcs) pc_dup++;
                pcs_cnt++;
                pc_q    = (pos < NPOS) ? score_tab[pos] : SCORE_W'(ONES);
                pos++;
                pc_pend = 1'b1;
                pc_cd   = int'($urandom_range(pc_lat_max, pc_lat_min));
            end
            prev_pcs = bus.pc_start;
        end
    end

    // Done pulse counter.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i = 0;
        while (!bus.done && i < 4000) begin
            @(negedge clk);
            i++;
        end
        check({tag, " done_seen"}, 32'(bus.done), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic scan_check(input string tag, input int ex_x, input int ex_y, input int ex_s,
                              input int ex_pcs, input int ex_rows);
        int p0 = pcs_cnt;
        int r0 = row_cnt;
        int d0 = done_cnt;
        int u0 = pc_dup;
        pulse_start();
        check({tag, " score_cleared"}, 32'(bus.best_score), 32'(ONES));
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        wait_done(tag);
        check({tag, " pc_starts"}, 32'(pcs_cnt - p0), 32'(ex_pcs));
        check({tag, " row_shifts"}, 32'(row_cnt - r0), 32'(ex_rows));
        check({tag, " done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, " pc_start_width"}, 32'(pc_dup - u0), 32'd0);
        check({tag, " busy_end"}, 32'(bus.busy), 32'd0);
        check({tag, " best_x"}, 32'(bus.best_x), 32'(ex_x));
        check({tag, " best_y"}, 32'(bus.best_y), 32'(ex_y));
        check({tag, " best_score"}, 32'(bus.best_score), 32'(ex_s));
    endtask

    initial begin
        int p0, s0, d0, q0, i;
        bus.start = 1'b0;
        bus.abort = 1'b0;
`ifdef SAD_THRESH_EN
        bus.thresh = '0;
`endif
        fill_tab(100);

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst lb_req", 32'(bus.lb_req), 32'd0);
        check("rst lb_row", 32'(bus.lb_row), 32'd0);
        check("rst pc_start", 32'(bus.pc_start), 32'd0);
        check("rst best_x", 32'(bus.best_x), 32'd0);
        check("rst best_y", 32'(bus.best_y), 32'd0);
        check("rst best_score", 32'(bus.best_score), 32'(ONES));
        #2 rst_n = 1'b1;

        // Scenario 1: uniform scores, immediate ack, popcount latency 3.
        s0 = shift_cnt;
        scan_check("s1", 0, 0, 100, 21, 3);
        check("s1 shifts", 32'(shift_cnt - s0), 32'd24);

        // Scenario 2: two equal minima, the earlier one must win.
        fill_tab(50);
        score_tab[1 * NX + 4] = 12'd5;
        score_tab[2 * NX + 6] = 12'd5;
        scan_check("s2", 4, 1, 5, 21, 3);

        // Scenario 3: random ack delay 0-4, popcount latency 1-6.
        lb_max = 4; pc_lat_min = 1; pc_lat_max = 6;
        q0 = req_drop;
        scan_check("s3", 4, 1, 5, 21, 3);
        check("s3 req_stable", 32'(req_drop - q0), 32'd0);

        // Scenario 4: mid-scan start ignored, abort while waiting on position (3,1).
        lb_max = 0; pc_lat_min = 6; pc_lat_max = 6;
        p0 = pcs_cnt; d0 = done_cnt;
        pulse_start();
        i = 0;
        while ((pcs_cnt - p0) < 3 && i < 2000) begin @(negedge clk); #1; i++; end
        pulse_start();
        i = 0;
        while ((pcs_cnt - p0) < 11 && i < 2000) begin @(negedge clk); #1; i++; end
        check("s4 reached_pos", 32'(pcs_cnt - p0), 32'd11);
        check("s4 busy_before", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("s4 abort_busy", 32'(bus.busy), 32'd0);
        check("s4 abort_lb_req", 32'(bus.lb_req), 32'd0);
        check("s4 abort_pc_start", 32'(bus.pc_start), 32'd0);
        // abort and start together in IDLE must not launch a scan
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("s4 idle_busy", 32'(bus.busy), 32'd0);
        check("s4 no_done", 32'(done_cnt - d0), 32'd0);
        check("s4 partial_x", 32'(bus.best_x), 32'd0);
        check("s4 partial_y", 32'(bus.best_y), 32'd0);
        check("s4 partial_score", 32'(bus.best_score), 32'd50);
        scan_check("s4r", 4, 1, 5, 21, 3);

        // Scenario 5: asynchronous reset while the sequencer is shifting.
        pc_lat_min = 3; pc_lat_max = 3;
        pulse_start();
        check("s5 in_shift", 32'(bus.lb_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("s5 rst_busy", 32'(bus.busy), 32'd0);
        check("s5 rst_lb_req", 32'(bus.lb_req), 32'd0);
        check("s5 rst_lb_row", 32'(bus.lb_row), 32'd0);
        check("s5 rst_best_x", 32'(bus.best_x), 32'd0);
        check("s5 rst_best_y", 32'(bus.best_y), 32'd0);
        check("s5 rst_best_score", 32'(bus.best_score), 32'(ONES));
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        fill_tab(100);
        scan_check("s5r", 0, 0, 100, 21, 3);

`ifdef SAD_THRESH_EN
        // Scenario 6: threshold early exit, then a threshold that never triggers.
        fill_tab(50);
        score_tab[2] = 12'd8;
        bus.thresh = 12'd10;
        scan_check("s6a", 2, 0, 8, 3, 1);
        check("s6a hit", 32'(bus.hit), 32'd1);
        bus.thresh = 12'd4;
        pulse_start();
        check("s6b hit_cleared", 32'(bus.hit), 32'd0);
        wait_done("s6b");
        check("s6b hit", 32'(bus.hit), 32'd0);
        check("s6b best_x", 32'(bus.best_x), 32'd2);
        check("s6b best_score", 32'(bus.best_score), 32'd8);
        scan_check("s6c", 2, 0, 8, 21, 3);
        check("s6c hit", 32'(bus.hit), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sad_scan_ctrl.md
Name: sad_scan_ctrl

Overview:
Raster-scan sequencer for the template-matching datapath. It steps the linebuffer one column at a time and primes it at each row start. For every valid window position it launches a popcount of the SAD (XOR) vector and tracks the minimum-score match position. Sits between the top-level host start/done interface and the linebuffer, SAD and linecounter (popcount) chain.

Parameters:
IMG_W, 320, image width in pixels
IMG_H, 240, image height in pixels
TPL_W, 50, template width (TPL_W*TPL_H = 4000 = SAD vector width)
TPL_H, 80, template height
SCORE_W, 12, popcount score width, must satisfy 2^SCORE_W > TPL_W*TPL_H

Ports:
clk  in  1  system clock
rst_n  in  1  reset
start  in  1  one-cycle pulse, begin a scan
abort  in  1  synchronous abort, return to IDLE
busy  out  1  scan in progress
done  out  1  one-cycle pulse, scan complete
lb_req  out  1  request linebuffer column shift
lb_ack  in  1  linebuffer has shifted; window updated
lb_row  out  1  qualifies lb_req: first shift of a new row (linebuffer clears its column pointer)
pc_start  out  1  one-cycle pulse, popcount the current SAD vector
pc_valid  in  1  popcount result valid (variable latency, ≥1 cycle)
pc_score  in  SCORE_W  popcount result
best_x  out  clog2(IMG_W)  column of best match (window left edge)
best_y  out  clog2(IMG_H)  row of best match (window top edge)
best_score  out  SCORE_W  minimum score found

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset: FSM=IDLE, busy=0, done=0, lb_req=0, lb_row=0, pc_start=0, best_x=0, best_y=0, best_score=all-ones, col/row/prime counters=0.
- States: IDLE, SHIFT, EVAL, WAIT, STEP, DONE.
- IDLE: start=1 → SHIFT next cycle. best_score←all-ones, x=y=0, prime_cnt=0. busy=1 from SHIFT until the DONE cycle inclusive.
- SHIFT: lb_req held high until lb_ack (ack in the same cycle as req is legal). lb_row=1 only on the first shift of each row. On req&&ack:
  - prime_cnt < TPL_W-1 → prime_cnt++, stay in SHIFT.
  - else → EVAL.
- EVAL: pc_start=1 for exactly one cycle → WAIT.
- WAIT: on pc_valid → compare, then STEP. pc_valid in any other state is ignored.
- Compare: pc_score < best_score (strict) → update best_x/y/score. Ties keep the earliest raster position.
- STEP:
  - x < IMG_W-TPL_W → x++, SHIFT (single shift, no prime).
  - else if y < IMG_H-TPL_H → x=0, y++, prime_cnt=0, SHIFT with lb_row.
  - else → DONE.
- DONE: done=1 for one cycle → IDLE. best_* hold until the next start.
- Total evaluations = (IMG_W-TPL_W+1)*(IMG_H-TPL_H+1).
- start while busy: ignored.
- abort (any state ≠ IDLE) → IDLE next cycle; lb_req/pc_start drop; done not pulsed; best_* keep partial values. abort has priority over every other transition. abort with start in the same IDLE cycle: stay IDLE.
- Async reset mid-scan: immediate return to reset values; any outstanding pc_valid is dropped.

Optional Feature:
SAD_THRESH_EN
- Defined: adds input thresh[SCORE_W-1:0] and output hit (1 bit, reset 0, cleared on start).
  - Compare with pc_score ≤ thresh → record position, hit=1, go directly to DONE (early exit).
  - No position ≤ thresh → full scan as normal, hit=0.
- Undefined: ports absent; always full minimum scan.

Decomposition:
- sad_pkg: state enum, SCORE_W derivation, coordinate width localparams (clog2 of IMG_W/IMG_H).
- Sub-module sad_best_tracker: clear/valid/score/x/y in, best_* out, strict-less compare. Also houses the threshold hit logic under SAD_THRESH_EN.

Test Plan:
1. Bench params IMG_W=8, IMG_H=4, TPL_W=2, TPL_H=2, lb_ack immediate, pc latency 3, all scores 100.
   → 21 pc_start pulses; 3 lb_row pulses; best=(0,0,100); single done pulse.
2. Same params; score 5 at (4,1), 5 at (6,2), others 50.
   → best_x=4, best_y=1, best_score=5 (tie keeps the first).
3. lb_ack delayed 0–4 random cycles; pc latency random 1–6.
   → lb_req stable until ack; exactly one pc_start per position; result identical to scenario 2.
4. abort asserted in WAIT at position (3,1); extra start pulses issued mid-scan.
   → IDLE next cycle, no done, busy=0. Mid-scan starts ignored. A later start rescans from (0,0) with best_score reset.
5. rst_n low mid-SHIFT.
   → all outputs at reset values asynchronously; a scan after release completes correctly.
6. SAD_THRESH_EN defined, thresh=10, score 8 at (2,0).
   → done after 3 evaluations, hit=1, best=(2,0,8). With thresh=4 → full 21-position scan, hit=0.
